// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: default per-port I/O addresses, the pin-change
// priming FSM state type and the alternate-function override bundle.
package gpio_pkg;

    localparam int GPIO_MAX_W = 8;

    localparam logic [5:0] PINB_ADDR  = 6'h03;
    localparam logic [5:0] DDRB_ADDR  = 6'h04;
    localparam logic [5:0] PORTB_ADDR = 6'h05;
    localparam logic [5:0] PINC_ADDR  = 6'h06;
    localparam logic [5:0] DDRC_ADDR  = 6'h07;
    localparam logic [5:0] PORTC_ADDR = 6'h08;
    localparam logic [5:0] PIND_ADDR  = 6'h09;
    localparam logic [5:0] DDRD_ADDR  = 6'h0A;
    localparam logic [5:0] PORTD_ADDR = 6'h0B;
    localparam logic [5:0] PINE_ADDR  = 6'h0C;
    localparam logic [5:0] DDRE_ADDR  = 6'h0D;
    localparam logic [5:0] PORTE_ADDR = 6'h0E;

    // Cycles spent in IDLE_PRIME counted before the comparison stage may be trusted.
    localparam logic [1:0] PRIME_CYCLES = 2'd2;

    typedef enum logic {
        IDLE_PRIME = 1'b0,
        ARMED      = 1'b1
    } prime_state_t;

    // Sized for the widest port; narrower ports use the low PORT_WIDTH bits.
    typedef struct packed {
        logic [GPIO_MAX_W-1:0] puoe;
        logic [GPIO_MAX_W-1:0] puov;
        logic [GPIO_MAX_W-1:0] ddoe;
        logic [GPIO_MAX_W-1:0] ddov;
        logic [GPIO_MAX_W-1:0] pvoe;
        logic [GPIO_MAX_W-1:0] pvov;
        logic [GPIO_MAX_W-1:0] dieoe;
        logic [GPIO_MAX_W-1:0] dieov;
    } gpio_ovr_t;

endpackage

// File: rtl/gpio_sync2.sv
// W-bit two-flop synchroniser for asynchronous inputs; async active-low reset.
module gpio_sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/gpio_port_px.sv
// Parametrised GPIO port (PORTx/DDRx/PINx, pad overrides, pin-change flag).
// Define GPIO_PCINT_EN to build the pin-change detector; otherwise pcif_o is 0.
module gpio_port_px
    import gpio_pkg::*;
#(
    parameter int         PORT_WIDTH = 8,
    parameter logic [5:0] PINX_ADDR  = 6'h06,
    parameter logic [5:0] DDRX_ADDR  = 6'h07,
    parameter logic [5:0] PORTX_ADDR = 6'h08
) (
    input  logic                  cp2,
    input  logic                  ireset,
    input  logic [5:0]            IO_Addr,
    input  logic                  iore,
    input  logic                  iowe,
    input  logic [7:0]            dbus_in,
    output logic [7:0]            dbus_out,
    output logic                  out_en,
    input  logic [PORT_WIDTH-1:0] pin_i,
    input  logic                  PUD,
    input  logic                  SLEEP,
    input  logic [PORT_WIDTH-1:0] puoe,
    input  logic [PORT_WIDTH-1:0] puov,
    input  logic [PORT_WIDTH-1:0] ddoe,
    input  logic [PORT_WIDTH-1:0] ddov,
    input  logic [PORT_WIDTH-1:0] pvoe,
    input  logic [PORT_WIDTH-1:0] pvov,
    input  logic [PORT_WIDTH-1:0] dieoe,
    input  logic [PORT_WIDTH-1:0] dieov,
    input  logic [PORT_WIDTH-1:0] pcmsk,
    input  logic                  pcie,
    input  logic                  pcif_clr,
    output logic                  pcif_o,
    output logic [PORT_WIDTH-1:0] din_o,
    output logic [PORT_WIDTH-1:0] pu_n_o,
    output logic [PORT_WIDTH-1:0] dd_o,
    output logic [PORT_WIDTH-1:0] pv_o,
    output logic [PORT_WIDTH-1:0] die_o,
    output prime_state_t          dbg_state
);

    localparam int W = PORT_WIDTH;

    logic [W-1:0] portx;
    logic [W-1:0] ddrx;
    logic [W-1:0] pin_sync;
    logic         sel_pin;
    logic         sel_ddr;
    logic         sel_port;

    assign sel_pin  = (IO_Addr == PINX_ADDR);
    assign sel_ddr  = (IO_Addr == DDRX_ADDR);
    assign sel_port = (IO_Addr == PORTX_ADDR);

    // Writing PINx toggles PORTx; PINx itself is read-only.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            portx <= '0;
            ddrx  <= '0;
        end else if (iowe) begin
            if (sel_port) begin
                portx <= dbus_in[W-1:0];
            end else if (sel_pin) begin
                portx <= portx ^ dbus_in[W-1:0];
            end
            if (sel_ddr) begin
                ddrx <= dbus_in[W-1:0];
            end
        end
    end

    always_comb begin
        out_en   = iore & (sel_pin | sel_ddr | sel_port);
        dbus_out = '0;
        if (out_en) begin
            if (sel_pin) begin
                dbus_out[W-1:0] = pin_sync;
            end else if (sel_ddr) begin
                dbus_out[W-1:0] = ddrx;
            end else begin
                dbus_out[W-1:0] = portx;
            end
        end
    end

    assign dd_o   = (ddoe & ddov) | (~ddoe & ddrx);
    assign pu_n_o = ~((puoe & puov) | (~puoe & portx & ~ddrx & {W{~PUD}}));
    assign pv_o   = (pvoe & pvov) | (~pvoe & portx);
    assign die_o  = (dieoe & dieov) | (~dieoe & {W{~SLEEP}});

    gpio_sync2 #(.W(W)) u_sync (
        .clk   (cp2),
        .rst_n (ireset),
        .d     (pin_i & die_o),
        .q     (pin_sync)
    );

    assign din_o = pin_sync;

`ifdef GPIO_PCINT_EN
    logic [W-1:0] pin_sync_d;
    logic [1:0]   prime_cnt;
    logic [1:0]   prime_cnt_nxt;
    logic         pc_hit;
    prime_state_t state;
    prime_state_t state_nxt;

    // Compare stage is registered (pc_hit) so the flag lands one edge after it.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            pin_sync_d <= '0;
            prime_cnt  <= '0;
            state      <= IDLE_PRIME;
            pc_hit     <= 1'b0;
            pcif_o     <= 1'b0;
        end else begin
            pin_sync_d <= pin_sync;
            prime_cnt  <= prime_cnt_nxt;
            state      <= state_nxt;
            pc_hit     <= (state == ARMED) & pcie & (|((pin_sync ^ pin_sync_d) & pcmsk));
            if (pc_hit) begin
                pcif_o <= 1'b1;
            end else if (pcif_clr) begin
                pcif_o <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        if (state == IDLE_PRIME) begin
            if (prime_cnt == PRIME_CYCLES) begin
                state_nxt = ARMED;
            end else begin
                prime_cnt_nxt = prime_cnt + 2'd1;
            end
        end
    end

    assign dbg_state = state;
`else
    wire unused_pcint = ^{pcmsk, pcie, pcif_clr};

    assign pcif_o    = 1'b0;
    assign dbg_state = IDLE_PRIME;
`endif

endmodule

// File: tb/tb_gpio_port_px.sv
// Randomised bench for gpio_port_px against a sample-history reference model.
module tb_gpio_port_px;

`ifdef GPIO_PCINT_EN
    localparam logic PC_ON = 1'b1;
`else
    localparam logic PC_ON = 1'b0;
`endif
    localparam logic [5:0] A_PIN  = 6'h06;
    localparam logic [5:0] A_DDR  = 6'h07;
    localparam logic [5:0] A_PORT = 6'h08;

    // clock / reset
    logic cp2 = 1'b0;
    logic ireset = 1'b0;
    always #5 cp2 = ~cp2;

    logic [5:0] IO_Addr = '0;
    logic       iore = 1'b0, iowe = 1'b0;
    logic [7:0] dbus_in = '0;
    logic [7:0] pin_i = '0;
    logic       PUD = 1'b0, SLEEP = 1'b0;
    logic [7:0] puoe = '0, puov = '0, ddoe = '0, ddov = '0;
    logic [7:0] pvoe = '0, pvov = '0, dieoe = '0, dieov = '0;
    logic [7:0] pcmsk = '0;
    logic       pcie = 1'b0, pcif_clr = 1'b0;

    logic [7:0] dbus_out, din_o, pu_n_o, dd_o, pv_o, die_o;
    logic       out_en, pcif_o, dbg_state;
    logic [7:0] dbus_out7;
    logic [6:0] din7, pu_n7, dd7, pv7, die7;
    logic       out_en7, pcif7, dbg7;

    gpio_port_px dut (
        .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en), .pin_i(pin_i),
        .PUD(PUD), .SLEEP(SLEEP), .puoe(puoe), .puov(puov), .ddoe(ddoe), .ddov(ddov),
        .pvoe(pvoe), .pvov(pvov), .dieoe(dieoe), .dieov(dieov), .pcmsk(pcmsk),
        .pcie(pcie), .pcif_clr(pcif_clr), .pcif_o(pcif_o), .din_o(din_o),
        .pu_n_o(pu_n_o), .dd_o(dd_o), .pv_o(pv_o), .die_o(die_o), .dbg_state(dbg_state)
    );

    gpio_port_px #(.PORT_WIDTH(7)) dut7 (
        .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
        .dbus_in(dbus_in), .dbus_out(dbus_out7), .out_en(out_en7), .pin_i(pin_i[6:0]),
        .PUD(PUD), .SLEEP(SLEEP), .puoe(puoe[6:0]), .puov(puov[6:0]), .ddoe(ddoe[6:0]),
        .ddov(ddov[6:0]), .pvoe(pvoe[6:0]), .pvov(pvov[6:0]), .dieoe(dieoe[6:0]),
        .dieov(dieov[6:0]), .pcmsk(pcmsk[6:0]), .pcie(pcie), .pcif_clr(pcif_clr),
        .pcif_o(pcif7), .din_o(din7), .pu_n_o(pu_n7), .dd_o(dd7), .pv_o(pv7),
        .die_o(die7), .dbg_state(dbg7)
    );

    // scoreboard / reference model
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] port_m = '0, ddr_m = '0;
    logic       flag_m = 1'b0;
    logic [7:0] exp_q[$];   // masked pad value sampled at each edge since reset
    logic [7:0] mask_q[$];  // effective pin-change mask at each edge since reset

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] die_exp();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = dieoe[i] ? dieov[i] : ~SLEEP;
        return r;
    endfunction

    function automatic logic [7:0] din_exp();
        int n = exp_q.size();
        return (n >= 2) ? exp_q[n-2] : 8'h00;
    endfunction

    always @(posedge cp2) begin
        if (!ireset) begin
            port_m = '0;
            ddr_m  = '0;
            flag_m = 1'b0;
            exp_q.delete();
            mask_q.delete();
        end else begin
            int  n;
            logic set;
            if (iowe && IO_Addr == A_PORT) port_m = dbus_in;
            if (iowe && IO_Addr == A_PIN)  port_m = port_m ^ dbus_in;
            if (iowe && IO_Addr == A_DDR)  ddr_m  = dbus_in;
            exp_q.push_back(pin_i & die_exp());
            mask_q.push_back(pcie ? pcmsk : 8'h00);
            n = exp_q.size();
            // Two consecutive synchronised post-reset samples differ under the mask seen at compare time.
            set = PC_ON && (n >= 5) && (((exp_q[n-4] ^ exp_q[n-5]) & mask_q[n-2]) != 0);
            if (set) flag_m = 1'b1;
            else if (pcif_clr) flag_m = 1'b0;
        end
    end

    task automatic check_all();
        logic [7:0] e_dd, e_pu_n, e_pv, e_rd;
        logic       e_oe;
        for (int i = 0; i < 8; i++) begin
            e_dd[i]   = ddoe[i] ? ddov[i] : ddr_m[i];
            e_pu_n[i] = ~(puoe[i] ? puov[i] : (port_m[i] & ~ddr_m[i] & ~PUD));
            e_pv[i]   = pvoe[i] ? pvov[i] : port_m[i];
        end
        e_oe = iore && (IO_Addr == A_PIN || IO_Addr == A_DDR || IO_Addr == A_PORT);
        e_rd = !e_oe ? 8'h00 : (IO_Addr == A_PIN) ? din_exp() : (IO_Addr == A_DDR) ? ddr_m : port_m;
        check("dd_o", dd_o, e_dd);
        check("pu_n_o", pu_n_o, e_pu_n);
        check("pv_o", pv_o, e_pv);
        check("die_o", die_o, die_exp());
        check("din_o", din_o, din_exp());
        check("pcif_o", {7'b0, pcif_o}, {7'b0, flag_m});
        check("out_en", {7'b0, out_en}, {7'b0, e_oe});
        check("dbus_out", dbus_out, e_rd);
        check("dbus_out_w7", dbus_out7, {1'b0, e_rd[6:0]});
        check("din_w7", {1'b0, din7}, {1'b0, din_exp() & 8'h7F});
    endtask

    // driver tasks
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge cp2);
            @(negedge cp2);
            check_all();
        end
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        iowe = 1'b1; IO_Addr = a; dbus_in = d;
        step();
        iowe = 1'b0;
    endtask

    task automatic io_read(input string tag, input logic [5:0] a, input logic [7:0] exp);
        iore = 1'b1; IO_Addr = a;
        #1;
        check(tag, dbus_out, exp);
        check({tag, "_oe"}, {7'b0, out_en}, 8'h01);
        iore = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        step(3);
        @(negedge cp2);
        ireset = 1'b1;
        step();
        check("rst_pu_n", pu_n_o, 8'hFF);
        check("rst_dd", dd_o, 8'h00);
        check("rst_pv", pv_o, 8'h00);
        check("rst_pcif", {7'b0, pcif_o}, 8'h00);

        // register write / readback
        io_write(A_DDR, 8'h0F);
        io_write(A_PORT, 8'h33);
        check("wr_dd", dd_o, 8'h0F);
        check("wr_pv", pv_o, 8'h33);
        check("wr_pu_n", pu_n_o, 8'hCF);
        io_read("rd_ddr", A_DDR, 8'h0F);
        io_read("rd_port", A_PORT, 8'h33);

        // PINx toggle
        io_write(A_PIN, 8'h11);
        check("toggle_pv", pv_o, 8'h22);
        io_read("toggle_rd", A_PORT, 8'h22);

        // synchroniser latency
        pin_i = 8'h80;
        step();
        check("sync_1edge", din_o, 8'h00);
        step();
        check("sync_2edge", din_o, 8'h80);
        io_read("rd_pin", A_PIN, 8'h80);
        iore = 1'b1; IO_Addr = A_PIN; #1;
        check("rd_pin_w7", dbus_out7, 8'h00);
        iore = 1'b0;

        // pin-change flag, clear, and set-over-clear
        pcmsk = 8'h01; pcie = 1'b1;
        step(2);
        pin_i = 8'h81;
        step(3);
        check("pc_early", {7'b0, pcif_o}, 8'h00);
        step();
        check("pc_set", {7'b0, pcif_o}, {7'b0, PC_ON});
        step(2);
        pcif_clr = 1'b1; step(); pcif_clr = 1'b0;
        check("pc_clr", {7'b0, pcif_o}, 8'h00);
        pin_i = 8'h80;
        step(3);
        pcif_clr = 1'b1; step(); pcif_clr = 1'b0;
        check("pc_set_wins", {7'b0, pcif_o}, {7'b0, PC_ON});

        // reset priming with pins held high
        pin_i = 8'hFF; pcmsk = 8'hFF;
        ireset = 1'b0;
        step(2);
        ireset = 1'b1;
        step(8);
        check("prime_quiet", {7'b0, pcif_o}, 8'h00);
        pin_i = 8'hFE;
        step(3);
        check("prime_early", {7'b0, pcif_o}, 8'h00);
        step();
        check("prime_toggle", {7'b0, pcif_o}, {7'b0, PC_ON});

        // overrides
        puoe = 8'hFF; puov = 8'hFF; PUD = 1'b1;
        step();
        check("ovr_pu", pu_n_o, 8'h00);
        dieoe = 8'hFF; dieov = 8'h00; pin_i = 8'hA5;
        step(2);
        check("ovr_die_din", din_o, 8'h00);
        dieoe = 8'h00; SLEEP = 1'b1;
        step();
        check("sleep_die", die_o, 8'h00);
        puoe = '0; puov = '0; PUD = 1'b0; SLEEP = 1'b0;
        step(2);

        // randomised traffic
        for (int c = 0; c < 600; c++) begin
            if (c % 40 == 0) begin
                puoe  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                puov  = 8'($urandom);
                ddoe  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                ddov  = 8'($urandom);
                pvoe  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                pvov  = 8'($urandom);
                dieoe = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                dieov = 8'($urandom);
                PUD   = ($urandom_range(0, 3) == 0);
                SLEEP = ($urandom_range(0, 5) == 0);
                pcmsk = 8'($urandom);
                pcie  = ($urandom_range(0, 9) != 0);
            end
            if ($urandom_range(0, 9) == 0) begin
                pin_i = 8'($urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                int b = $urandom_range(0, 7);
                pin_i[b] = ~pin_i[b];
            end
            iowe     = ($urandom_range(0, 3) == 0);
            iore     = ($urandom_range(0, 1) == 0);
            IO_Addr  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(6, 8));
            dbus_in  = 8'($urandom);
            pcif_clr = ($urandom_range(0, 7) == 0);
            ireset   = !(c >= 300 && c < 302);
            step();
        end
        iowe = 1'b0; iore = 1'b0; pcif_clr = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
